decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: XLEN, default 32, width of pc_in/pc_out.
REQ-002 Parameter: BR_FULL, default 1; 1 = resolve all six RV32I branch conditions, 0 = BEQ-only resolution (any branch taken iff eq).
REQ-003 Parameter: ILL_CNT_W, default 8, width of illegal-instruction counter.
REQ-004 Ports: clk  in  1  clock, all state on rising edge; one clock; reset is synchronous and active-low (rst_n).
REQ-005 Ports: rst_n  in  1  synchronous active-low reset.
REQ-006 Ports: in_valid  in  1 / in_ready  out  1  upstream handshake.
REQ-007 Ports: instr  in  32 / pc_in  in  XLEN  instruction and its PC.
REQ-008 Ports: eq, lt, ltu  in  1 each  rs1-vs-rs2 compare flags, valid with instr.
REQ-009 Ports: flush  in  1  kill held and incoming instruction.
REQ-010 Ports: out_valid  out  1 / out_ready  in  1  downstream handshake.
REQ-011 Ports: op1sel out 1; op2sel out 2; funcsel out 1; memwr out 1; regwr out 1; ra2sel out 1; wasel out 1; wbsel out 2; pcsel out 2; pc_out out XLEN; illegal out 1 -- all registered.
REQ-012 Ports: ill_cnt  out  ILL_CNT_W  saturating count of accepted illegal instructions.

Function
REQ-013 Encodings: op1sel 0=rs1,1=upper imm; op2sel 0=rs2,1=I-imm,2=S-imm,3=pc; wbsel 0=alu,1=mem,2=pc+4; pcsel 0=pc+4,1=branch,2=jal,3=jalr; ra2sel 0=rs2,1=rd; wasel 0=rd,1=x1.
REQ-014 Decode (opcode=instr[6:0]): 0110011 ALU: op2sel0 funcsel0 regwr1 wbsel0; 0010011 ALUi: op2sel1 funcsel1 regwr1; 0000011 Load: op2sel1 funcsel1 regwr1 wbsel1; 0100011 Store: op2sel2 funcsel1 memwr1 regwr0.
REQ-015 Decode: 1101111 JAL: regwr1 wbsel2 wasel0 pcsel2; 1100111 JALR: op2sel1 funcsel1 regwr1 wbsel2 pcsel3; 0110111 LUI: op1sel1 ra2sel1 regwr1; 0010111 AUIPC: op1sel1 op2sel3 regwr1.
REQ-016 Branch 1100011: regwr0 memwr0 op2sel0; pcsel1 if taken else 0; BR_FULL=1 funct3 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu; funct3 010/011 illegal.
REQ-017 Fields not listed for an opcode SHALL be 0.
REQ-018 Any other opcode: illegal=1, regwr=0, memwr=0, pcsel=0, others 0.
REQ-019 in_ready = !out_valid || out_ready (combinational, single stage).
REQ-020 Accept when in_valid && in_ready && !flush: register decoded bundle and pc_in, out_valid=1 next cycle; latency 1 cycle.
REQ-021 out_valid && !out_ready: all outputs held stable.
REQ-022 out_valid && out_ready && no accept: out_valid=0 next cycle.
REQ-023 flush: out_valid=0 next cycle, incoming instr dropped, ill_cnt unchanged, flush wins over accept.
REQ-024 ill_cnt increments by 1 on each accepted illegal instruction; saturates at all-ones, no wrap.
REQ-025 Outputs with out_valid=0 are don't-care except regwr and memwr, which SHALL be 0.

Reset
REQ-026 rst_n=0 at a clk edge: out_valid=0, all control outputs 0, pc_out=0, illegal=0, ill_cnt=0; overrides accept and flush.
REQ-027 Reset mid-stall SHALL discard held instruction; in_ready=1 first cycle after release.

Verification
REQ-028 ADD 0x00B50533, pc 0x100, out_ready=1 -> next cycle out_valid=1, regwr1 op2sel0 wbsel0 pcsel0 pc_out=0x100.
REQ-029 BLT (funct3 100) with lt=1, BR_FULL=1 -> pcsel1; same with lt=0 -> pcsel0; BR_FULL=0, eq=0, lt=1 -> pcsel0.
REQ-030 Store accepted, out_ready=0 for 3 cycles -> memwr1 op2sel2 stable, in_ready=0, next instr not taken until out_ready=1.
REQ-031 Opcode 0x7F x 260 with ILL_CNT_W=8 -> illegal=1 each, ill_cnt=255 saturated, regwr=memwr=0.
REQ-032 flush concurrent with valid JAL -> out_valid=0 next cycle; then JALR -> pcsel3 wbsel2 regwr1.
REQ-033 rst_n=0 while stalled with valid LUI -> out_valid=0, ill_cnt=0, in_ready=1 after release.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage
// Single-entry RV32I decode stage. Decodes the incoming instruction into
// datapath control selects, resolves the branch direction from the
// rs1-vs-rs2 compare flags, and holds the decoded bundle in one output
// register with a valid/ready handshake on both sides.
//
// Parameters:
//   XLEN      - width of pc_in/pc_out
//   BR_FULL   - 1: all six RV32I branch conditions; 0: any branch taken iff eq
//   ILL_CNT_W - width of the saturating illegal-instruction counter
//
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   in_valid/in_ready   - upstream handshake (in_ready is combinational)
//   instr, pc_in        - instruction and its PC
//   eq, lt, ltu         - compare flags, valid alongside instr
//   flush               - kills the held and the incoming instruction
//   out_valid/out_ready - downstream handshake
//   op1sel..pcsel       - registered control selects
//   pc_out              - registered PC of the held instruction
//   illegal             - held instruction was not a recognised encoding
//   ill_cnt             - saturating count of accepted illegal instructions
module decode_stage #(
    parameter int XLEN      = 32,
    parameter int BR_FULL   = 1,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [XLEN-1:0]      pc_in,
    input  logic                 eq,
    input  logic                 lt,
    input  logic                 ltu,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 op1sel,
    output logic [1:0]           op2sel,
    output logic                 funcsel,
    output logic                 memwr,
    output logic                 regwr,
    output logic                 ra2sel,
    output logic                 wasel,
    output logic [1:0]           wbsel,
    output logic [1:0]           pcsel,
    output logic [XLEN-1:0]      pc_out,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_cnt
);

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    // Register/immediate fields are consumed by later stages, not here.
    assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

    logic       d_op1sel;
    logic [1:0] d_op2sel;
    logic       d_funcsel;
    logic       d_memwr;
    logic       d_regwr;
    logic       d_ra2sel;
    logic       d_wasel;
    logic [1:0] d_wbsel;
    logic [1:0] d_pcsel;
    logic       d_illegal;
    logic       br_taken;
    logic       br_bad;
    logic       accept;

    // A stage with one register: it can take a new instruction whenever
    // it is empty or its current content is leaving this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Branch resolution. funct3 010/011 are not branch encodings and are
    // rejected in both modes; the reduced mode treats every other branch
    // as a BEQ.
    always_comb begin
        br_taken = 1'b0;
        br_bad   = 1'b0;
        if (BR_FULL != 0) begin
            case (funct3)
                3'b000:  br_taken = eq;
                3'b001:  br_taken = !eq;
                3'b100:  br_taken = lt;
                3'b101:  br_taken = !lt;
                3'b110:  br_taken = ltu;
                3'b111:  br_taken = !ltu;
                default: br_bad   = 1'b1;
            endcase
        end else begin
            if (funct3 == 3'b010 || funct3 == 3'b011) begin
                br_bad = 1'b1;
            end else begin
                br_taken = eq;
            end
        end
    end

    // Opcode decode. Every field starts at zero so anything not named for
    // an opcode stays zero, and an unknown opcode yields only illegal=1.
    always_comb begin
        d_op1sel  = 1'b0;
        d_op2sel  = 2'd0;
        d_funcsel = 1'b0;
        d_memwr   = 1'b0;
        d_regwr   = 1'b0;
        d_ra2sel  = 1'b0;
        d_wasel   = 1'b0;
        d_wbsel   = 2'd0;
        d_pcsel   = 2'd0;
        d_illegal = 1'b0;
        case (opcode)
            OP_ALU: begin
                d_regwr = 1'b1;
            end
            OP_ALUI: begin
                d_op2sel  = 2'd1;
                d_funcsel = 1'b1;
                d_regwr   = 1'b1;
            end
            OP_LOAD: begin
                d_op2sel  = 2'd1;
                d_funcsel = 1'b1;
                d_regwr   = 1'b1;
                d_wbsel   = 2'd1;
            end
            OP_STORE: begin
                d_op2sel  = 2'd2;
                d_funcsel = 1'b1;
                d_memwr   = 1'b1;
            end
            OP_JAL: begin
                d_regwr = 1'b1;
                d_wbsel = 2'd2;
                d_pcsel = 2'd2;
            end
            OP_JALR: begin
                d_op2sel  = 2'd1;
                d_funcsel = 1'b1;
                d_regwr   = 1'b1;
                d_wbsel   = 2'd2;
                d_pcsel   = 2'd3;
            end
            OP_LUI: begin
                d_op1sel = 1'b1;
                d_ra2sel = 1'b1;
                d_regwr  = 1'b1;
            end
            OP_AUIPC: begin
                d_op1sel = 1'b1;
                d_op2sel = 2'd3;
                d_regwr  = 1'b1;
            end
            OP_BRANCH: begin
                if (br_bad) begin
                    d_illegal = 1'b1;
                end else begin
                    d_pcsel = br_taken ? 2'd1 : 2'd0;
                end
            end
            default: begin
                d_illegal = 1'b1;
            end
        endcase
    end

    // Output register. Whenever the stage empties (flush or drain without
    // a replacement) regwr and memwr are cleared so an invalid slot can
    // never look like a write; the other fields are left as they were.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            op1sel    <= 1'b0;
            op2sel    <= 2'd0;
            funcsel   <= 1'b0;
            memwr     <= 1'b0;
            regwr     <= 1'b0;
            ra2sel    <= 1'b0;
            wasel     <= 1'b0;
            wbsel     <= 2'd0;
            pcsel     <= 2'd0;
            pc_out    <= '0;
            illegal   <= 1'b0;
            ill_cnt   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            memwr     <= 1'b0;
            regwr     <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            op1sel    <= d_op1sel;
            op2sel    <= d_op2sel;
            funcsel   <= d_funcsel;
            memwr     <= d_memwr;
            regwr     <= d_regwr;
            ra2sel    <= d_ra2sel;
            wasel     <= d_wasel;
            wbsel     <= d_wbsel;
            pcsel     <= d_pcsel;
            pc_out    <= pc_in;
            illegal   <= d_illegal;
            if (d_illegal && (ill_cnt != '1)) begin
                ill_cnt <= ill_cnt + ILL_CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            memwr     <= 1'b0;
            regwr     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
// Directed bench for decode_stage. A full-branch instance (dut) and a
// BEQ-only instance (dut_beq) share every input; most checks look at dut,
// the reduced-branch behaviour is checked on dut_beq. Inputs change 1ns
// after the rising edge and outputs are sampled at that same point.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] pc_in;
    logic        eq, lt, ltu;
    logic        flush;
    logic        out_ready;

    logic        in_ready,  out_valid;
    logic        op1sel, funcsel, memwr, regwr, ra2sel, wasel, illegal;
    logic [1:0]  op2sel, wbsel, pcsel;
    logic [31:0] pc_out;
    logic [7:0]  ill_cnt;

    logic        b_in_ready, b_out_valid;
    logic        b_op1sel, b_funcsel, b_memwr, b_regwr, b_ra2sel, b_wasel, b_illegal;
    logic [1:0]  b_op2sel, b_wbsel, b_pcsel;
    logic [31:0] b_pc_out;
    logic [7:0]  b_ill_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    decode_stage #(.XLEN(32), .BR_FULL(1), .ILL_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_in(pc_in), .eq(eq), .lt(lt), .ltu(ltu),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .op1sel(op1sel), .op2sel(op2sel), .funcsel(funcsel), .memwr(memwr),
        .regwr(regwr), .ra2sel(ra2sel), .wasel(wasel), .wbsel(wbsel),
        .pcsel(pcsel), .pc_out(pc_out), .illegal(illegal), .ill_cnt(ill_cnt)
    );

    decode_stage #(.XLEN(32), .BR_FULL(0), .ILL_CNT_W(8)) dut_beq (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .instr(instr), .pc_in(pc_in), .eq(eq), .lt(lt), .ltu(ltu),
        .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
        .op1sel(b_op1sel), .op2sel(b_op2sel), .funcsel(b_funcsel), .memwr(b_memwr),
        .regwr(b_regwr), .ra2sel(b_ra2sel), .wasel(b_wasel), .wbsel(b_wbsel),
        .pcsel(b_pcsel), .pc_out(b_pc_out), .illegal(b_illegal), .ill_cnt(b_ill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs expected control fields in the same order as ctl below.
    function automatic logic [12:0] mk(input logic o1, input logic [1:0] o2,
                                       input logic fs, input logic mw, input logic rw,
                                       input logic r2, input logic wa,
                                       input logic [1:0] wb, input logic [1:0] ps,
                                       input logic il);
        return {o1, o2, fs, mw, rw, r2, wa, wb, ps, il};
    endfunction

    logic [12:0] ctl;
    assign ctl = {op1sel, op2sel, funcsel, memwr, regwr, ra2sel, wasel, wbsel, pcsel, illegal};

    localparam logic [12:0] C_ADD   = 13'b0_00_0_0_1_0_0_00_00_0;
    localparam logic [12:0] C_STORE = 13'b0_10_1_1_0_0_0_00_00_0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] i, input logic [31:0] pc,
                                 input logic e, input logic l, input logic lu,
                                 input logic f, input logic rdy);
        in_valid  = v;
        instr     = i;
        pc_in     = pc;
        eq        = e;
        lt        = l;
        ltu       = lu;
        flush     = f;
        out_ready = rdy;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 32'h00B50533, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        $display("[TB] reset state");
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_ctl", 32'(ctl), 32'd0);
        checkOutput("rst_pc_out", pc_out, 32'd0);
        checkOutput("rst_ill_cnt", 32'(ill_cnt), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        rst_n = 1'b1;
        $display("[TB] decode of each opcode class");
        applyStimulus(1'b1, 32'h00B50533, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("add_valid", 32'(out_valid), 32'd1);
        checkOutput("add_ctl", 32'(ctl), 32'(C_ADD));
        checkOutput("add_pc", pc_out, 32'h100);

        applyStimulus(1'b1, 32'h00150513, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("addi_ctl", 32'(ctl), 32'(mk(0, 2'd1, 1, 0, 1, 0, 0, 2'd0, 2'd0, 0)));

        applyStimulus(1'b1, 32'h00052503, 32'h108, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("lw_ctl", 32'(ctl), 32'(mk(0, 2'd1, 1, 0, 1, 0, 0, 2'd1, 2'd0, 0)));

        applyStimulus(1'b1, 32'h123452B7, 32'h10C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("lui_ctl", 32'(ctl), 32'(mk(1, 2'd0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 0)));

        applyStimulus(1'b1, 32'h00000517, 32'h110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("auipc_ctl", 32'(ctl), 32'(mk(1, 2'd3, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0)));

        $display("[TB] branch resolution");
        applyStimulus(1'b1, 32'h00B54463, 32'h120, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("blt_lt1_ctl", 32'(ctl), 32'(mk(0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 0)));
        checkOutput("blt_lt1_beqonly_pcsel", 32'(b_pcsel), 32'd0);

        applyStimulus(1'b1, 32'h00B54463, 32'h124, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("blt_lt0_pcsel", 32'(pcsel), 32'd0);
        checkOutput("blt_eq1_beqonly_pcsel", 32'(b_pcsel), 32'd1);

        applyStimulus(1'b1, 32'h00B51463, 32'h128, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("bne_ne_pcsel", 32'(pcsel), 32'd1);

        applyStimulus(1'b1, 32'h00B57463, 32'h12C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("bgeu_ltu1_pcsel", 32'(pcsel), 32'd0);

        applyStimulus(1'b1, 32'h00B55463, 32'h130, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("bge_ge_pcsel", 32'(pcsel), 32'd1);

        applyStimulus(1'b1, 32'h00B52463, 32'h134, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        exp_cnt = 1;
        checkOutput("br010_ctl", 32'(ctl), 32'(mk(0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1)));
        checkOutput("br010_ill_cnt", 32'(ill_cnt), 32'(exp_cnt));

        $display("[TB] store held under back-pressure");
        applyStimulus(1'b1, 32'h00B52023, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("sw_ctl", 32'(ctl), 32'(C_STORE));
        applyStimulus(1'b1, 32'h00052503, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_ctl", 32'(ctl), 32'(C_STORE));
            checkOutput("stall_pc", pc_out, 32'h200);
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("after_stall_ctl", 32'(ctl), 32'(mk(0, 2'd1, 1, 0, 1, 0, 0, 2'd1, 2'd0, 0)));
        checkOutput("after_stall_pc", pc_out, 32'h204);

        $display("[TB] illegal opcode stream and counter saturation");
        applyStimulus(1'b1, 32'h0000007F, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 260; k++) begin
            tick();
            if (exp_cnt < 255) exp_cnt++;
            checkOutput("ill_ctl", 32'(ctl), 32'(mk(0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1)));
            checkOutput("ill_cnt_step", 32'(ill_cnt), 32'(exp_cnt));
        end
        checkOutput("ill_cnt_sat", 32'(ill_cnt), 32'd255);

        $display("[TB] flush and jumps");
        applyStimulus(1'b1, 32'h008000EF, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_regwr", 32'(regwr), 32'd0);
        checkOutput("flush_memwr", 32'(memwr), 32'd0);
        checkOutput("flush_ill_cnt", 32'(ill_cnt), 32'd255);

        applyStimulus(1'b1, 32'h00008067, 32'h304, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("jalr_valid", 32'(out_valid), 32'd1);
        checkOutput("jalr_ctl", 32'(ctl), 32'(mk(0, 2'd1, 1, 0, 1, 0, 0, 2'd2, 2'd3, 0)));
        checkOutput("jalr_pc", pc_out, 32'h304);

        applyStimulus(1'b1, 32'h008000EF, 32'h308, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("jal_ctl", 32'(ctl), 32'(mk(0, 2'd0, 0, 0, 1, 0, 0, 2'd2, 2'd2, 0)));

        applyStimulus(1'b1, 32'h00B52023, 32'h30C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h00B52023, 32'h310, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("drain_valid", 32'(out_valid), 32'd0);
        checkOutput("drain_memwr", 32'(memwr), 32'd0);

        $display("[TB] reset while stalled");
        applyStimulus(1'b1, 32'h123452B7, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("lui2_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_ill_cnt", 32'(ill_cnt), 32'd0);
        checkOutput("midrst_ctl", 32'(ctl), 32'd0);
        checkOutput("midrst_pc", pc_out, 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("postrst_in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("postrst_valid", 32'(out_valid), 32'd0);
        checkOutput("postrst_in_ready2", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
